// File: rtl/shared_ptw.sv
// Sv39 page-table walker shared by the I- and D-TLB.
//
// Starts a walk when the shared TLB reports a lookup miss. PTEs are read one at a time
// over a req/gnt/rvalid port with a single outstanding request. The walk ends in one of
// two ways: a one-cycle refill on shared_tlb_update_o, or a one-cycle ptw_error_o pulse
// tagged with the originating TLB.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  abort the current walk and suppress its refill
//   satp_ppn_i               root page-table PPN
//   asid_i, v_st_enbl_i      captured at walk start and copied into the refill
//   shared_tlb_access_i      shared TLB performed a lookup last cycle
//   shared_tlb_hit_i         that lookup hit
//   shared_tlb_vaddr_i       looked-up virtual address
//   itlb_req_i               lookup came from the ITLB
//   shared_tlb_miss_o        walker busy, so the TLB must stall
//   shared_tlb_update_o      refill record, valid for one cycle
//   mem_req_o, mem_addr_o    PTE read request and physical address
//   mem_gnt_i, mem_rvalid_i  request accepted / read data valid
//   mem_rdata_i              PTE read data
//   ptw_error_o              page-fault pulse
//   ptw_error_itlb_o         the fault belongs to an ITLB walk
//   bad_vaddr_o              faulting vaddr, held until the next walk starts

package shared_ptw_pkg;
   parameter int unsigned ASID_WIDTH = 16;

   typedef struct packed {
      logic [43:0] ppn;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_cva6_t;

   typedef struct packed {
      logic                  valid;
      logic [26:0]           vpn;
      logic [1:0]            is_page;
      pte_cva6_t             content;
      logic                  v_st_enbl;
      logic [ASID_WIDTH-1:0] asid;
   } tlb_update_cva6_t;
endpackage

module shared_ptw
   import shared_ptw_pkg::*;
#(
   parameter int unsigned VLEN = 64,
   parameter int unsigned XLEN = 64,
   parameter int unsigned PLEN = 56
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [43:0]           satp_ppn_i,
   input  logic [ASID_WIDTH-1:0] asid_i,
   input  logic                  v_st_enbl_i,
   input  logic                  shared_tlb_access_i,
   input  logic                  shared_tlb_hit_i,
   input  logic [VLEN-1:0]       shared_tlb_vaddr_i,
   input  logic                  itlb_req_i,
   output logic                  shared_tlb_miss_o,
   output tlb_update_cva6_t      shared_tlb_update_o,
   output logic                  mem_req_o,
   output logic [PLEN-1:0]       mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [XLEN-1:0]       mem_rdata_i,
   output logic                  ptw_error_o,
   output logic                  ptw_error_itlb_o,
   output logic [VLEN-1:0]       bad_vaddr_o
);

   typedef enum logic [2:0] {StIdle, StWaitGrant, StWaitRvalid, StDrain, StError} state_e;

   state_e                state_q, state_d;
   logic [1:0]            level_q, level_d;
   logic [PLEN-1:0]       ptr_q, ptr_d;
   logic [VLEN-1:0]       vaddr_q, vaddr_d;
   logic                  itlb_q, itlb_d;
   logic [ASID_WIDTH-1:0] asid_q, asid_d;
   logic                  v_st_q, v_st_d;
   tlb_update_cva6_t      update_q, update_d;

   pte_cva6_t pte;
   logic      leaf_fault;
   logic      unused_rdata;

   // Sv39 PTE layout: ppn in [53:10], RSW [9:8] ignored, flags in [7:0].
   assign pte = pte_cva6_t'({mem_rdata_i[53:10], mem_rdata_i[7:0]});
   assign unused_rdata = ^{mem_rdata_i[XLEN-1:54], mem_rdata_i[9:8]};

   // Permission check against the requesting TLB, plus superpage alignment.
   assign leaf_fault = (itlb_q ? !pte.x : !pte.r) ||
                       ((level_q == 2'd0) && (pte.ppn[17:0] != '0)) ||
                       ((level_q == 2'd1) && (pte.ppn[8:0] != '0));

   always_comb begin
      state_d        = state_q;
      level_d        = level_q;
      ptr_d          = ptr_q;
      vaddr_d        = vaddr_q;
      itlb_d         = itlb_q;
      asid_d         = asid_q;
      v_st_d         = v_st_q;
      update_d       = update_q;
      update_d.valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (shared_tlb_access_i && !shared_tlb_hit_i && !flush_i) begin
               vaddr_d = shared_tlb_vaddr_i;
               itlb_d  = itlb_req_i;
               asid_d  = asid_i;
               v_st_d  = v_st_enbl_i;
               level_d = 2'd0;
               // vpn*8 is below 4 KiB, so concatenation is the same as the page-base add.
               ptr_d   = PLEN'({satp_ppn_i, shared_tlb_vaddr_i[38:30], 3'b000});
               state_d = StWaitGrant;
            end
         end
         StWaitGrant: begin
            if (flush_i) begin
               // A granted request still has a response on the way that must be absorbed.
               state_d = mem_gnt_i ? StDrain : StIdle;
            end else if (mem_gnt_i) begin
               state_d = StWaitRvalid;
            end
         end
         StWaitRvalid: begin
            if (mem_rvalid_i) begin
               if (flush_i) begin
                  state_d = StIdle;
               end else if (!pte.v || (pte.w && !pte.r)) begin
                  state_d = StError;
               end else if (pte.r || pte.x) begin
                  if (leaf_fault) begin
                     state_d = StError;
                  end else begin
                     update_d.valid     = 1'b1;
                     update_d.vpn       = vaddr_q[38:12];
                     update_d.is_page   = {level_q == 2'd0, level_q == 2'd1};
                     update_d.content   = pte;
                     update_d.v_st_enbl = v_st_q;
                     update_d.asid      = asid_q;
                     state_d            = StIdle;
                  end
               end else if (level_q == 2'd2) begin
                  state_d = StError;
               end else begin
                  level_d = level_q + 2'd1;
                  ptr_d   = PLEN'({pte.ppn, (level_q == 2'd0) ? vaddr_q[29:21] : vaddr_q[20:12],
                                   3'b000});
                  state_d = StWaitGrant;
               end
            end else if (flush_i) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (mem_rvalid_i) begin
               state_d = StIdle;
            end
         end
         StError: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         level_q  <= 2'd0;
         ptr_q    <= '0;
         vaddr_q  <= '0;
         itlb_q   <= 1'b0;
         asid_q   <= '0;
         v_st_q   <= 1'b0;
         update_q <= '0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         ptr_q    <= ptr_d;
         vaddr_q  <= vaddr_d;
         itlb_q   <= itlb_d;
         asid_q   <= asid_d;
         v_st_q   <= v_st_d;
         update_q <= update_d;
      end
   end

   assign shared_tlb_miss_o   = (state_q != StIdle);
   assign shared_tlb_update_o = update_q;
   assign mem_req_o           = (state_q == StWaitGrant);
   assign mem_addr_o          = ptr_q;
   assign ptw_error_o         = (state_q == StError);
   assign ptw_error_itlb_o    = (state_q == StError) && itlb_q;
   assign bad_vaddr_o         = vaddr_q;

endmodule

// File: tb/tb_shared_ptw.sv
// Directed bench for shared_ptw: a table of complete walks plus hand-written flush/hit cases.
module tb_shared_ptw;
   import shared_ptw_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  flush = 1'b0;
   logic [43:0]           satp_ppn = 44'h80000;
   logic [ASID_WIDTH-1:0] asid = '0;
   logic                  v_st = 1'b0;
   logic                  access = 1'b0;
   logic                  hit = 1'b0;
   logic [63:0]           vaddr = '0;
   logic                  itlb = 1'b0;
   logic                  miss;
   tlb_update_cva6_t      upd;
   logic                  mem_req;
   logic [55:0]           mem_addr;
   logic                  gnt = 1'b0;
   logic                  rvalid = 1'b0;
   logic [63:0]           rdata = '0;
   logic                  err;
   logic                  err_itlb;
   logic [63:0]           bad_vaddr;

   int n_checks = 0;
   int n_fail   = 0;

   shared_ptw dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .flush_i             (flush),
      .satp_ppn_i          (satp_ppn),
      .asid_i              (asid),
      .v_st_enbl_i         (v_st),
      .shared_tlb_access_i (access),
      .shared_tlb_hit_i    (hit),
      .shared_tlb_vaddr_i  (vaddr),
      .itlb_req_i          (itlb),
      .shared_tlb_miss_o   (miss),
      .shared_tlb_update_o (upd),
      .mem_req_o           (mem_req),
      .mem_addr_o          (mem_addr),
      .mem_gnt_i           (gnt),
      .mem_rvalid_i        (rvalid),
      .mem_rdata_i         (rdata),
      .ptw_error_o         (err),
      .ptw_error_itlb_o    (err_itlb),
      .bad_vaddr_o         (bad_vaddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic            itlb;
      logic [63:0]     vaddr;
      int              nlev;
      logic [2:0][63:0] pte;
      logic [2:0][55:0] addr;
      logic            exp_err;
      logic [1:0]      exp_isp;
      logic [43:0]     exp_ppn;
      logic            poke;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic run_walk(input int k);
      vec_t             v;
      logic [ASID_WIDTH-1:0] a;
      v = vecs[k];
      a = ASID_WIDTH'(16'h00A0 + 16'(k));
      @(negedge clk);
      check({v.name, " idle_before"}, 64'(miss), 64'd0);
      access = 1'b1; hit = 1'b0; vaddr = v.vaddr; itlb = v.itlb; asid = a; v_st = k[0];
      for (int l = 0; l < v.nlev; l++) begin
         @(negedge clk);
         // Optional poke: a second miss arriving while busy must be ignored.
         access = v.poke && (l == 0);
         if (v.poke) begin vaddr = 64'h7FFFF000; itlb = ~v.itlb; end
         check({v.name, " miss_busy"}, 64'(miss), 64'd1);
         check({v.name, " req"}, 64'(mem_req), 64'd1);
         check({v.name, " addr"}, 64'(mem_addr), 64'(v.addr[l]));
         gnt = 1'b1;
         @(negedge clk);
         access = 1'b0; gnt = 1'b0;
         check({v.name, " req_drop"}, 64'(mem_req), 64'd0);
         rvalid = 1'b1; rdata = v.pte[l];
      end
      @(negedge clk);
      rvalid = 1'b0; rdata = '0;
      if (v.exp_err) begin
         check({v.name, " err"}, 64'(err), 64'd1);
         check({v.name, " err_itlb"}, 64'(err_itlb), 64'(v.itlb));
         check({v.name, " bad_vaddr"}, bad_vaddr, v.vaddr);
         check({v.name, " no_update"}, 64'(upd.valid), 64'd0);
      end else begin
         check({v.name, " upd_valid"}, 64'(upd.valid), 64'd1);
         check({v.name, " is_page"}, 64'(upd.is_page), 64'(v.exp_isp));
         check({v.name, " vpn"}, 64'(upd.vpn), 64'(v.vaddr[38:12]));
         check({v.name, " ppn"}, 64'(upd.content.ppn), 64'(v.exp_ppn));
         check({v.name, " asid"}, 64'(upd.asid), 64'(a));
         check({v.name, " v_st"}, 64'(upd.v_st_enbl), 64'(k[0]));
         check({v.name, " no_err"}, 64'(err), 64'd0);
      end
      @(negedge clk);
      check({v.name, " upd_one_cycle"}, 64'(upd.valid), 64'd0);
      check({v.name, " err_one_cycle"}, 64'(err), 64'd0);
      check({v.name, " idle_after"}, 64'(miss), 64'd0);
      check({v.name, " req_idle"}, 64'(mem_req), 64'd0);
   endtask

   // Starts a dtlb miss on 0x40001000 and leaves the walker in WAIT_GRANT at a negedge.
   task automatic start_walk();
      @(negedge clk);
      access = 1'b1; hit = 1'b0; vaddr = 64'h40001000; itlb = 1'b0;
      @(negedge clk);
      access = 1'b0;
      check("start req", 64'(mem_req), 64'd1);
   endtask

   initial begin
      //        name        itlb  vaddr         nlev  pte (lvl2,lvl1,lvl0)
      vecs[0] = '{"leaf1g", 1'b0, 64'h40001000, 1, {64'h0, 64'h0, 64'h3000000B},
                  {56'h0, 56'h0, 56'h80000008}, 1'b0, 2'b10, 44'hC0000, 1'b0};
      vecs[1] = '{"walk4k", 1'b1, 64'h40001000, 3, {64'h2000100B, 64'h20000801, 64'h20000401},
                  {56'h80002008, 56'h80001000, 56'h80000008}, 1'b0, 2'b00, 44'h80004, 1'b0};
      vecs[2] = '{"mis2m", 1'b0, 64'h40001000, 2, {64'h0, 64'h20000C03, 64'h20000401},
                  {56'h0, 56'h80001000, 56'h80000008}, 1'b1, 2'b00, 44'h0, 1'b0};
      vecs[3] = '{"inval", 1'b1, 64'h40001000, 1, {64'h0, 64'h0, 64'h20000400},
                  {56'h0, 56'h0, 56'h80000008}, 1'b1, 2'b00, 44'h0, 1'b0};
      vecs[4] = '{"leaf2m", 1'b0, 64'h40201000, 2, {64'h0, 64'h20080003, 64'h20000401},
                  {56'h0, 56'h80001008, 56'h80000008}, 1'b0, 2'b01, 44'h80200, 1'b0};
      vecs[5] = '{"dnor", 1'b0, 64'h40001000, 1, {64'h0, 64'h0, 64'h30000009},
                  {56'h0, 56'h0, 56'h80000008}, 1'b1, 2'b00, 44'h0, 1'b0};
      vecs[6] = '{"wnor", 1'b1, 64'h40001000, 1, {64'h0, 64'h0, 64'h30000005},
                  {56'h0, 56'h0, 56'h80000008}, 1'b1, 2'b00, 44'h0, 1'b0};
      vecs[7] = '{"lvl2nl", 1'b1, 64'h40001000, 3, {64'h20001001, 64'h20000801, 64'h20000401},
                  {56'h80002008, 56'h80001000, 56'h80000008}, 1'b1, 2'b00, 44'h0, 1'b0};
      vecs[8] = '{"busy", 1'b0, 64'h40001000, 1, {64'h0, 64'h0, 64'h3000000B},
                  {56'h0, 56'h0, 56'h80000008}, 1'b0, 2'b10, 44'hC0000, 1'b1};

      // Reset state.
      @(negedge clk);
      check("rst miss", 64'(miss), 64'd0);
      check("rst req", 64'(mem_req), 64'd0);
      check("rst addr", 64'(mem_addr), 64'd0);
      check("rst upd", 64'(upd), 64'd0);
      check("rst err", 64'(err), 64'd0);
      check("rst bad_vaddr", bad_vaddr, 64'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 9; k++) run_walk(k);

      // Hit: no walk.
      @(negedge clk);
      access = 1'b1; hit = 1'b1; vaddr = 64'h40001000;
      @(negedge clk);
      access = 1'b0; hit = 1'b0;
      check("hit miss", 64'(miss), 64'd0);
      check("hit req", 64'(mem_req), 64'd0);

      // Flush in WAIT_RVALID, response three cycles later, then a new miss.
      start_walk();
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("drain miss", 64'(miss), 64'd1);
      check("drain req", 64'(mem_req), 64'd0);
      @(negedge clk);
      check("drain hold", 64'(miss), 64'd1);
      rvalid = 1'b1; rdata = 64'h3000000B;
      @(negedge clk);
      rvalid = 1'b0;
      check("drain idle", 64'(miss), 64'd0);
      check("drain no_upd", 64'(upd.valid), 64'd0);
      check("drain no_err", 64'(err), 64'd0);
      run_walk(0);

      // Flush in WAIT_GRANT without grant: straight back to idle.
      start_walk();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fgnt miss", 64'(miss), 64'd0);
      check("fgnt req", 64'(mem_req), 64'd0);

      // Flush coinciding with rvalid: response consumed, nothing reported.
      start_walk();
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b1; rdata = 64'h3000000B; flush = 1'b1;
      @(negedge clk);
      rvalid = 1'b0; flush = 1'b0;
      check("frv miss", 64'(miss), 64'd0);
      check("frv no_upd", 64'(upd.valid), 64'd0);
      check("frv no_err", 64'(err), 64'd0);
      run_walk(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shared_ptw.md
Name: shared_ptw

Overview:
- Hardware Sv39 page-table walker that services misses from the shared TLB.
- Takes the shared TLB's registered access/hit/vaddr/itlb_req indication, walks the page table in memory through a single-outstanding request/grant/rvalid port, and returns a `tlb_update_cva6_t` refill to the shared TLB.
- Reports page faults, tagged with the originating TLB (I or D).

Parameters:
- tlb_update_cva6_t, logic: refill struct with fields valid, vpn[26:0], is_page[1:0], content (pte_cva6_t), v_st_enbl, asid.
- pte_cva6_t, logic: Sv39 PTE struct with fields ppn[43:0], d, a, g, u, x, w, r, v.
- PLEN, 56: physical address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort walk, suppress refill
- satp_ppn_i  in  44  root table PPN
- asid_i  in  ASID_WIDTH  ASID captured at walk start
- v_st_enbl_i  in  1  translation enabled; copied into refill
- shared_tlb_access_i  in  1  shared TLB lookup performed last cycle
- shared_tlb_hit_i  in  1  that lookup hit
- shared_tlb_vaddr_i  in  VLEN  looked-up vaddr
- itlb_req_i  in  1  lookup originated from ITLB
- shared_tlb_miss_o  out  1  walker busy (state != IDLE)
- shared_tlb_update_o  out  $bits(tlb_update_cva6_t)  refill
- mem_req_o  out  1  PTE read request
- mem_addr_o  out  PLEN  PTE physical address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  XLEN  PTE data
- ptw_error_o  out  1  page-fault pulse
- ptw_error_itlb_o  out  1  fault belongs to ITLB walk
- bad_vaddr_o  out  VLEN  faulting vaddr, held until next walk

Behaviour:
- Reset: state IDLE; all outputs 0; level 0; internal latches 0.
- States: IDLE, WAIT_GRANT, WAIT_RVALID, DRAIN, ERROR.
- **IDLE**
  - If shared_tlb_access_i && !shared_tlb_hit_i && !flush_i: latch vaddr, itlb_req_i, asid_i, v_st_enbl_i.
  - Set level=0 and ptr = {satp_ppn_i,12'b0} + vaddr[38:30]*8, then go to WAIT_GRANT.
  - Accesses arriving while not IDLE are ignored; shared_tlb_miss_o=1 tells the TLB to stall.
- **WAIT_GRANT**
  - mem_req_o=1, mem_addr_o=ptr.
  - On mem_gnt_i go to WAIT_RVALID; mem_req_o drops the next cycle.
  - Only one request is outstanding.
- **WAIT_RVALID**: on mem_rvalid_i, decode pte=mem_rdata_i:
  - !v or (w && !r): ERROR.
  - Leaf (r or x):
    - Faults if itlb walk && !x, or dtlb walk && !r, or misaligned superpage (level 0 with ppn[17:0]!=0, level 1 with ppn[8:0]!=0). A fault goes to ERROR.
    - Otherwise drive shared_tlb_update_o for exactly one cycle (the cycle after rvalid): valid=1, vpn=vaddr[38:12], is_page={level==0, level==1}, content=pte, asid=latched, v_st_enbl=latched. Then go to IDLE.
  - Non-leaf:
    - At level 2: ERROR.
    - Otherwise level++ and ptr = {pte.ppn,12'b0} + vpn[next level]*8, where level 1 uses vaddr[29:21] and level 2 uses vaddr[20:12]. Then go to WAIT_GRANT.
- **ERROR**: ptw_error_o=1 for one cycle, ptw_error_itlb_o=latched itlb flag, bad_vaddr_o=latched vaddr; then go to IDLE. No refill is issued.
- **Flush**
  - In IDLE or ERROR, or in WAIT_GRANT without gnt that cycle: go to IDLE immediately. A pending error pulse is still emitted.
  - In WAIT_GRANT with gnt the same cycle, or in WAIT_RVALID: go to DRAIN. DRAIN waits for mem_rvalid_i, discards the data, then goes to IDLE. No update, no error.
  - If rvalid and flush coincide in WAIT_RVALID, the response is consumed, with no update and no error.
- Asynchronous reset mid-walk returns to IDLE at once. An in-flight memory response after reset is the memory side's responsibility.
- Address arithmetic is truncated to PLEN. vpn*8 is a 12-bit offset and never carries beyond the page.
- Latency, with single-cycle grant and one-cycle rvalid:
  - 1G leaf: 4 cycles from access to update.
  - Each extra level adds 2 cycles (4k leaf: 8 cycles).

Test Plan:
- 1G leaf hit path: satp_ppn=0x80000, vaddr=0x40001000 (dtlb), gnt/rvalid next cycle, rdata=0x3000000B.
  - Required: mem_addr=0x80000008.
  - Required: update valid=1 for one cycle, is_page=2'b10, vpn=0x40001, content.ppn=0xC0000.
- 3-level 4k walk (itlb): level0 pte=0x20000401 (ppn 0x80001, non-leaf), level1 pte=0x20000801 (ppn 0x80002), level2 pte=0x2000100B.
  - Required: addrs 0x80000008, 0x80001000, 0x80002008.
  - Required: update is_page=2'b00.
  - Required: shared_tlb_miss_o=1 throughout the walk.
- Misaligned 2M leaf: level1 returns ppn=0x80003 with r=v=1.
  - Required: ptw_error_o pulse, ptw_error_itlb_o=0, bad_vaddr_o=vaddr, no update.
- Invalid PTE (v=0) on an itlb walk at level 0.
  - Required: ptw_error_o=1, ptw_error_itlb_o=1, mem_req_o never reasserted.
- flush_i in WAIT_RVALID, rvalid 3 cycles later.
  - Required: DRAIN; no update, no error; IDLE the cycle after rvalid.
  - Required: a new miss is then accepted.
- Access with hit=1, or arriving while busy.
  - Required: no walk is started; mem_req_o stays 0 (or the current walk is unaffected).
